xor_gate: RTL and testbench
===========================

// Module: xor_gate
//
// PURPOSE
//   Bitwise two-input exclusive-OR of two WIDTH-bit operands, with an optional
//   output register, a reduction-parity flag and a saturating output-transition
//   counter for activity monitoring.
//   Leaf primitive used by parity, adder and comparator datapaths.
//   The default configuration (WIDTH=1) is the classic 1-bit XOR gate.
//
// PARAMETERS
//   WIDTH    1   operand/result width in bits (>=1)
//   REG_OUT  1   1: out registered, one-cycle latency; 0: out purely combinational
//   CNT_W    16  width of toggle_cnt (>=1)
//
// PORTS
//   clk         input   1      rising-edge clock
//   reset       input   1      asynchronous, active-high reset
//   in1         input   WIDTH  operand A
//   in2         input   WIDTH  operand B
//   out         output  WIDTH  in1 ^ in2 (bitwise)
//   parity      output  1      ^out (reduction XOR of current out)
//   toggle_cnt  output  CNT_W  count of clock edges on which out changed value
//
// BEHAVIOUR
//   - Function: out[i] = in1[i] ^ in2[i] for every bit i.
//     Truth table per bit: 00->0, 10->1, 01->1, 11->0.
//   - REG_OUT=1:
//     - out updates on each rising clk edge to in1^in2 sampled at that edge.
//     - Latency: exactly 1 cycle; no enable, the register loads every cycle.
//   - REG_OUT=0:
//     - out follows in1^in2 combinationally, zero latency, independent of clk/reset.
//   - parity: combinational from out; always consistent with the visible out.
//   - toggle_cnt:
//     - An internal register prev_out holds out as of the last edge.
//     - On each rising edge, if the new out value != prev_out, toggle_cnt increments by 1.
//     - Saturates at all-ones; it never wraps.
//     - Any bit change counts as one transition, regardless of how many bits changed.
//   - Reset (asynchronous, active-high), effective immediately and independent of clk:
//     - REG_OUT=1: out = 0, parity = 0.
//     - toggle_cnt = 0 and prev_out = 0 (both configurations).
//     - Asserting reset mid-operation discards the pending result.
//     - First capture occurs at the first rising edge after reset deasserts.
//   - Simultaneous events: reset dominates any clock edge.
//   - Unknown inputs: X/Z on an input bit yields X on that out bit; no masking.
//
// TESTING
//   1. Truth table (WIDTH=1, REG_OUT=1, clk period 10, vectors held 120 units each):
//      (0,0)->out=0; (1,0)->out=1; (0,1)->out=1; (1,1)->out=0.
//   2. Latency check: change inputs just after an edge.
//      out holds its old value until the next edge, then shows the new XOR.
//      With REG_OUT=0, out changes within the same timestep.
//   3. Reset mid-operation: with out=1, assert reset between edges.
//      out=0, parity=0, toggle_cnt=0 immediately.
//      After release, inputs (1,0) give out=1 on the first edge.
//   4. Vector mode (WIDTH=8): in1=8'hA5, in2=8'h0F -> out=8'hAA, parity=0.
//      in1=8'hFF, in2=8'h01 -> out=8'hFE, parity=1.
//   5. Counter (CNT_W=2): alternate (1,0)/(0,0) every cycle.
//      toggle_cnt goes 1,2,3 and stays 3 (saturated).
//      Holding inputs constant leaves toggle_cnt unchanged.

Source files
------------

// File: rtl/xor_gate.sv
// ---------------------------------------------------------------------------
// xor_gate
//   Bitwise two-input exclusive-OR of two WIDTH-bit operands. The result can
//   be registered or purely combinational. The block also provides a
//   reduction-parity flag and a saturating count of output transitions,
//   which is used for activity monitoring.
//   This is a leaf primitive for parity, adder and comparator datapaths.
//   With WIDTH=1 it is the classic 1-bit XOR gate.
//
// Parameters
//   WIDTH    operand/result width in bits (>=1)
//   REG_OUT  1: out registered (one-cycle latency); 0: out combinational
//   CNT_W    width of toggle_cnt (>=1)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   in1, in2    operands
//   out         in1 ^ in2 (bitwise), registered or combinational
//   parity      reduction XOR of the visible out
//   toggle_cnt  saturating count of clock edges on which out changed value
// ---------------------------------------------------------------------------
module xor_gate #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             parity,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] xor_p0;
    logic [WIDTH-1:0] prev_out_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Stage p0: combinational XOR; X/Z on an input bit propagates as X.
    assign xor_p0 = in1 ^ in2;

    // Stage p1: prev_out_p1 holds out as of the last edge. In registered
    // mode, it is also the visible output register. This means one flop
    // serves both as the result and as the transition-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_out_p1 <= '0;
            cnt_p1      <= '0;
        end else begin
            if (xor_p0 != prev_out_p1)
                cnt_p1 <= sat_inc(cnt_p1);
            prev_out_p1 <= xor_p0;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            assign out = prev_out_p1;
        end else begin : g_comb
            assign out = xor_p0;
        end
    endgenerate

    assign parity     = ^out;
    assign toggle_cnt = cnt_p1;

endmodule

// File: tb/tb_xor_gate.sv
module tb_xor_gate;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // scalar registered (u_dut) and scalar combinational (u_comb) share a/b
    logic a = 1'b0, b = 1'b0;
    logic        o_dut, p_dut, o_comb, p_comb;
    logic [15:0] c_dut, c_comb;

    // 8-bit registered and combinational share v1/v2
    logic [7:0]  v1 = 8'h00, v2 = 8'h00;
    logic [7:0]  o_vreg, o_vcomb;
    logic        p_vreg, p_vcomb;
    logic [15:0] c_vreg, c_vcomb;

    // 2-bit counter instance
    logic        k1 = 1'b0, k2 = 1'b0;
    logic        o_cnt, p_cnt;
    logic [1:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xor_gate #(.WIDTH(1), .REG_OUT(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in1(a), .in2(b),
        .out(o_dut), .parity(p_dut), .toggle_cnt(c_dut));

    xor_gate #(.WIDTH(1), .REG_OUT(0), .CNT_W(16)) u_comb (
        .clk(clk), .reset(reset), .in1(a), .in2(b),
        .out(o_comb), .parity(p_comb), .toggle_cnt(c_comb));

    xor_gate #(.WIDTH(8), .REG_OUT(1), .CNT_W(16)) u_vreg (
        .clk(clk), .reset(reset), .in1(v1), .in2(v2),
        .out(o_vreg), .parity(p_vreg), .toggle_cnt(c_vreg));

    xor_gate #(.WIDTH(8), .REG_OUT(0), .CNT_W(16)) u_vcomb (
        .clk(clk), .reset(reset), .in1(v1), .in2(v2),
        .out(o_vcomb), .parity(p_vcomb), .toggle_cnt(c_vcomb));

    xor_gate #(.WIDTH(1), .REG_OUT(1), .CNT_W(2)) u_cnt (
        .clk(clk), .reset(reset), .in1(k1), .in2(k2),
        .out(o_cnt), .parity(p_cnt), .toggle_cnt(c_cnt));

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (o_dut !== 1'b0) begin bad++; $display("FAIL rst_out got=%b exp=0", o_dut); end
        total++; if (p_dut !== 1'b0) begin bad++; $display("FAIL rst_parity got=%b exp=0", p_dut); end
        total++; if (c_dut !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", c_dut); end
        total++; if (o_vreg !== 8'h00) begin bad++; $display("FAIL rst_vout got=%h exp=00", o_vreg); end
        total++; if (c_cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt2 got=%0d exp=0", c_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] vec [4];
        logic ea;
        vec[0] = 2'b00; vec[1] = 2'b10; vec[2] = 2'b01; vec[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = vec[i][1];
            b = vec[i][0];
            ea = (vec[i][1] == vec[i][0]) ? 1'b0 : 1'b1;
            #1;
            total++; if (o_comb !== ea) begin bad++; $display("FAIL tt_comb[%0d] got=%b exp=%b", i, o_comb, ea); end
            #119;
            total++; if (o_dut !== ea) begin bad++; $display("FAIL tt_reg[%0d] got=%b exp=%b", i, o_dut, ea); end
            total++; if (p_dut !== ea) begin bad++; $display("FAIL tt_parity[%0d] got=%b exp=%b", i, p_dut, ea); end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a = 1'b1; b = 1'b0;
        @(posedge clk);
        #1;
        a = 1'b1; b = 1'b1;
        #1;
        total++; if (o_dut !== 1'b1) begin bad++; $display("FAIL lat_hold got=%b exp=1", o_dut); end
        total++; if (o_comb !== 1'b0) begin bad++; $display("FAIL lat_comb got=%b exp=0", o_comb); end
        @(posedge clk);
        #1;
        total++; if (o_dut !== 1'b0) begin bad++; $display("FAIL lat_update got=%b exp=0", o_dut); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 1'b1; b = 1'b0;
        @(posedge clk);
        #1;
        total++; if (o_dut !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", o_dut); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (o_dut !== 1'b0) begin bad++; $display("FAIL mid_out got=%b exp=0", o_dut); end
        total++; if (p_dut !== 1'b0) begin bad++; $display("FAIL mid_parity got=%b exp=0", p_dut); end
        total++; if (c_dut !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", c_dut); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (o_dut !== 1'b1) begin bad++; $display("FAIL mid_first got=%b exp=1", o_dut); end
        total++; if (c_dut !== 16'd1) begin bad++; $display("FAIL mid_first_cnt got=%0d exp=1", c_dut); end
    endtask

    task automatic test_vector();
        logic [7:0] x1 [2];
        logic [7:0] x2 [2];
        logic [7:0] eo [2];
        logic       ep [2];
        x1[0] = 8'hA5; x2[0] = 8'h0F; eo[0] = 8'hAA; ep[0] = 1'b0;
        x1[1] = 8'hFF; x2[1] = 8'h01; eo[1] = 8'hFE; ep[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            v1 = x1[i]; v2 = x2[i];
            @(negedge clk);
            total++; if (o_vreg !== eo[i]) begin bad++; $display("FAIL vec_out[%0d] got=%h exp=%h", i, o_vreg, eo[i]); end
            total++; if (p_vreg !== ep[i]) begin bad++; $display("FAIL vec_parity[%0d] got=%b exp=%b", i, p_vreg, ep[i]); end
        end
    endtask

    task automatic test_random();
        int exp_cnt;
        int prev;
        int cur;
        int par;
        v1 = 8'h00; v2 = 8'h00;
        do_reset();
        exp_cnt = 0;
        prev = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0) begin
                v1 = 8'($urandom);
                v2 = 8'($urandom);
            end
            cur = (int'(v1) + int'(v2) - 2 * int'(v1 & v2)); // XOR via arithmetic
            par = $countones(cur) % 2;
            #1;
            total++; if (o_vcomb !== 8'(cur)) begin bad++; $display("FAIL rnd_comb[%0d] got=%h exp=%h", i, o_vcomb, 8'(cur)); end
            total++; if (p_vcomb !== 1'(par)) begin bad++; $display("FAIL rnd_comb_par[%0d] got=%b exp=%0d", i, p_vcomb, par); end
            @(negedge clk);
            if (cur != prev && exp_cnt < 65535) exp_cnt++;
            prev = cur;
            total++; if (o_vreg !== 8'(cur)) begin bad++; $display("FAIL rnd_reg[%0d] got=%h exp=%h", i, o_vreg, 8'(cur)); end
            total++; if (p_vreg !== 1'(par)) begin bad++; $display("FAIL rnd_par[%0d] got=%b exp=%0d", i, p_vreg, par); end
            total++; if (c_vreg !== 16'(exp_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, c_vreg, exp_cnt); end
            total++; if (c_vcomb !== 16'(exp_cnt)) begin bad++; $display("FAIL rnd_ccnt[%0d] got=%0d exp=%0d", i, c_vcomb, exp_cnt); end
        end
    endtask

    task automatic test_counter_sat();
        int exp_cnt;
        k1 = 1'b0; k2 = 1'b0;
        do_reset();
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            k1 = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_cnt = (exp_cnt + 1 > 3) ? 3 : exp_cnt + 1;
            total++; if (c_cnt !== 2'(exp_cnt)) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, c_cnt, exp_cnt); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (c_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold[%0d] got=%0d exp=3", i, c_cnt); end
        end
    endtask

    task automatic test_hold_constant();
        int base;
        a = 1'b1; b = 1'b0;
        do_reset();
        @(negedge clk);
        base = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (c_dut !== 16'(base)) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=%0d", i, c_dut, base); end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_reset_mid();
        test_vector();
        test_random();
        test_counter_sat();
        test_hold_constant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
